// File: rtl/cal_pkg.sv
// Shared encodings and size helpers for the calculator controller.
// Used by cal_calc_fsm and cal_digit_acc.
package cal_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_OPA    = 2'b01,
        ST_OPB    = 2'b10,
        ST_RESULT = 2'b11
    } cal_state_e;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10
    } cal_op_e;

    typedef enum logic [2:0] {
        K_NONE,
        K_CLR,
        K_EQ,
        K_OP,
        K_DIG
    } cal_key_e;

    function automatic int cal_maxv(input int digits);
        int v;
        v = 1;
        for (int i = 0; i < digits; i++) begin
            v = v * 10;
        end
        return v - 1;
    endfunction

    function automatic int cal_opw(input int digits);
        return $clog2(cal_maxv(digits) + 1);
    endfunction

endpackage

// File: rtl/cal_digit_acc.sv
// Single decimal operand accumulator: value, digit count, load and clear.
// Leading zeros are absorbed without consuming a digit slot.
module cal_digit_acc
    import cal_pkg::*;
#(
    parameter int DIGITS = 2,
    parameter int OPW    = cal_opw(DIGITS)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clr,
    input  logic           load_en,
    input  logic [OPW-1:0] load_val,
    input  logic           first,
    input  logic           acc,
    input  logic [3:0]     digit,
    output logic [OPW-1:0] val,
    output logic           empty
);

    localparam int CNTW = $clog2(DIGITS + 1);

    logic [OPW-1:0]  val_q, val_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [OPW+3:0]  ext;
    logic            full;
    logic            lead_zero;

    always_comb begin
        val_d     = val_q;
        cnt_d     = cnt_q;
        ext       = {4'b0000, val_q};
        full      = (cnt_q == CNTW'(DIGITS));
        lead_zero = (val_q == '0) && (digit == 4'd0);
        if (clr) begin
            val_d = '0;
            cnt_d = '0;
        end else if (load_en) begin
            val_d = load_val;
            cnt_d = CNTW'(DIGITS);
        end else if (first) begin
            val_d = OPW'(digit);
            cnt_d = (digit != 4'd0) ? CNTW'(1) : '0;
        end else if (acc && !full && !lead_zero) begin
            // x*10 as (x<<3)+(x<<1); count bound keeps it within MAXV
            val_d = OPW'((ext << 3) + (ext << 1) + (OPW + 4)'(digit));
            cnt_d = cnt_q + CNTW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            val_q <= '0;
            cnt_q <= '0;
        end else begin
            val_q <= val_d;
            cnt_q <= cnt_d;
        end
    end

    assign val   = val_q;
    assign empty = (cnt_q == '0);

endmodule

// File: rtl/cal_calc_fsm.sv
// Calculator controller: two decimal operands, add/sub/mul, result chaining.
// Define CAL_MUL_EN to enable op_mul and the inferred multiplier.
module cal_calc_fsm
    import cal_pkg::*;
#(
    parameter  int DIGITS = 2,
    localparam int MAXV   = cal_maxv(DIGITS),
    localparam int OPW    = cal_opw(DIGITS),
    localparam int RESW   = 2 * OPW
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            digit_vld,
    input  logic [3:0]      digit,
    input  logic            op_add,
    input  logic            op_sub,
    input  logic            op_mul,
    input  logic            op_eq,
    input  logic            op_clr,
    output logic [1:0]      state,
    output logic [1:0]      op,
    output logic [OPW-1:0]  operand_a,
    output logic [OPW-1:0]  operand_b,
    output logic [RESW-1:0] result_mag,
    output logic            result_neg,
    output logic [RESW-1:0] disp_val
);

    cal_state_e      state_q, state_d;
    cal_op_e         op_q, op_d;
    logic [RESW-1:0] res_mag_q, res_mag_d;
    logic            res_neg_q, res_neg_d;

    cal_key_e        key;
    cal_op_e         key_op;
    logic            mul_key;
    logic            dig_ok;

    logic [OPW-1:0]  a_val, b_val;
    logic            b_empty;
    logic            unused_a_empty;
    logic            a_clr, a_load, a_first, a_acc;
    logic            b_clr, b_acc;

    logic [RESW-1:0] ext_a, ext_b;
    logic [RESW-1:0] arith_mag;
    logic            arith_neg;
    logic            chain_ok;

`ifdef CAL_MUL_EN
    assign mul_key = op_mul;
`else
    logic unused_op_mul;
    assign unused_op_mul = op_mul;
    assign mul_key       = 1'b0;
`endif

    assign dig_ok = digit_vld && (digit <= 4'd9);

    // Only the highest-priority pulse survives; the rest are dropped
    always_comb begin
        key    = K_NONE;
        key_op = OP_ADD;
        if (op_clr) begin
            key = K_CLR;
        end else if (op_eq) begin
            key = K_EQ;
        end else if (op_add) begin
            key    = K_OP;
            key_op = OP_ADD;
        end else if (op_sub) begin
            key    = K_OP;
            key_op = OP_SUB;
        end else if (mul_key) begin
            key    = K_OP;
            key_op = OP_MUL;
        end else if (dig_ok) begin
            key = K_DIG;
        end
    end

    assign ext_a = RESW'(a_val);
    assign ext_b = RESW'(b_val);

    always_comb begin
        arith_mag = ext_a + ext_b;
        arith_neg = 1'b0;
        unique case (op_q)
            OP_SUB: begin
                if (ext_a >= ext_b) begin
                    arith_mag = ext_a - ext_b;
                end else begin
                    arith_mag = ext_b - ext_a;
                    arith_neg = 1'b1;
                end
            end
`ifdef CAL_MUL_EN
            OP_MUL: arith_mag = ext_a * ext_b;
`endif
            default: arith_mag = ext_a + ext_b;
        endcase
    end

    assign chain_ok = !res_neg_q && (res_mag_q <= RESW'(MAXV));

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        res_mag_d = res_mag_q;
        res_neg_d = res_neg_q;
        a_clr     = 1'b0;
        a_load    = 1'b0;
        a_first   = 1'b0;
        a_acc     = 1'b0;
        b_clr     = 1'b0;
        b_acc     = 1'b0;
        if (key == K_CLR) begin
            state_d   = ST_IDLE;
            op_d      = OP_ADD;
            res_mag_d = '0;
            res_neg_d = 1'b0;
            a_clr     = 1'b1;
            b_clr     = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (key == K_DIG) begin
                        a_first = 1'b1;
                        state_d = ST_OPA;
                    end else if (key == K_OP) begin
                        op_d    = key_op;
                        a_clr   = 1'b1;
                        b_clr   = 1'b1;
                        state_d = ST_OPB;
                    end
                end
                ST_OPA: begin
                    if (key == K_DIG) begin
                        a_acc = 1'b1;
                    end else if (key == K_OP) begin
                        op_d    = key_op;
                        b_clr   = 1'b1;
                        state_d = ST_OPB;
                    end
                end
                ST_OPB: begin
                    if (key == K_DIG) begin
                        b_acc = 1'b1;
                    end else if (key == K_OP && b_empty) begin
                        op_d = key_op;
                    end else if (key == K_EQ) begin
                        res_mag_d = arith_mag;
                        res_neg_d = arith_neg;
                        state_d   = ST_RESULT;
                    end
                end
                ST_RESULT: begin
                    if (key == K_DIG) begin
                        a_first = 1'b1;
                        b_clr   = 1'b1;
                        state_d = ST_OPA;
                    end else if (key == K_OP && chain_ok) begin
                        a_load  = 1'b1;
                        op_d    = key_op;
                        b_clr   = 1'b1;
                        state_d = ST_OPB;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_ADD;
            res_mag_q <= '0;
            res_neg_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            res_mag_q <= res_mag_d;
            res_neg_q <= res_neg_d;
        end
    end

    cal_digit_acc #(
        .DIGITS (DIGITS),
        .OPW    (OPW)
    ) u_acc_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (a_clr),
        .load_en  (a_load),
        .load_val (res_mag_q[OPW-1:0]),
        .first    (a_first),
        .acc      (a_acc),
        .digit    (digit),
        .val      (a_val),
        .empty    (unused_a_empty)
    );

    cal_digit_acc #(
        .DIGITS (DIGITS),
        .OPW    (OPW)
    ) u_acc_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (b_clr),
        .load_en  (1'b0),
        .load_val ('0),
        .first    (1'b0),
        .acc      (b_acc),
        .digit    (digit),
        .val      (b_val),
        .empty    (b_empty)
    );

    always_comb begin
        unique case (state_q)
            ST_OPB:    disp_val = RESW'(b_val);
            ST_RESULT: disp_val = res_mag_q;
            default:   disp_val = RESW'(a_val);
        endcase
    end

    assign state      = state_q;
    assign op         = op_q;
    assign operand_a  = a_val;
    assign operand_b  = b_val;
    assign result_mag = res_mag_q;
    assign result_neg = res_neg_q;

endmodule

// File: tb/tb_cal_calc_fsm.sv
// Directed-vector bench for cal_calc_fsm with DIGITS=2.
// MUL expectations follow CAL_MUL_EN.
module tb_cal_calc_fsm;

    localparam int OPW  = 7;
    localparam int RESW = 14;

    localparam logic [5:0] K_DIG = 6'b000001;
    localparam logic [5:0] K_MUL = 6'b000010;
    localparam logic [5:0] K_SUB = 6'b000100;
    localparam logic [5:0] K_ADD = 6'b001000;
    localparam logic [5:0] K_EQ  = 6'b010000;
    localparam logic [5:0] K_CLR = 6'b100000;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            digit_vld = 1'b0;
    logic [3:0]      digit = 4'd0;
    logic            op_add = 1'b0;
    logic            op_sub = 1'b0;
    logic            op_mul = 1'b0;
    logic            op_eq = 1'b0;
    logic            op_clr = 1'b0;
    logic [1:0]      state;
    logic [1:0]      op;
    logic [OPW-1:0]  operand_a;
    logic [OPW-1:0]  operand_b;
    logic [RESW-1:0] result_mag;
    logic            result_neg;
    logic [RESW-1:0] disp_val;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    cal_calc_fsm #(.DIGITS(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .digit_vld  (digit_vld),
        .digit      (digit),
        .op_add     (op_add),
        .op_sub     (op_sub),
        .op_mul     (op_mul),
        .op_eq      (op_eq),
        .op_clr     (op_clr),
        .state      (state),
        .op         (op),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .result_mag (result_mag),
        .result_neg (result_neg),
        .disp_val   (disp_val)
    );

    task automatic drive(input logic [5:0] k, input logic [3:0] d);
        @(negedge clk);
        {op_clr, op_eq, op_add, op_sub, op_mul, digit_vld} = k;
        digit = d;
    endtask

    task automatic idle();
        drive(6'b0, 4'd0);
    endtask

    task automatic dig(input logic [3:0] d);
        drive(K_DIG, d);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        total++; if (state !== 2'b00) begin bad++; $display("FAIL reset_state got=%0d exp=0", state); end
        total++; if (op !== 2'b00) begin bad++; $display("FAIL reset_op got=%0d exp=0", op); end
        total++; if (operand_a !== 7'd0) begin bad++; $display("FAIL reset_a got=%0d exp=0", operand_a); end
        total++; if (operand_b !== 7'd0) begin bad++; $display("FAIL reset_b got=%0d exp=0", operand_b); end
        total++; if (result_mag !== 14'd0) begin bad++; $display("FAIL reset_mag got=%0d exp=0", result_mag); end
        total++; if (result_neg !== 1'b0) begin bad++; $display("FAIL reset_neg got=%0d exp=0", result_neg); end
        total++; if (disp_val !== 14'd0) begin bad++; $display("FAIL reset_disp got=%0d exp=0", disp_val); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        drive(K_CLR, 0); dig(4); dig(2); idle();
        total++; if (state !== 2'b01) begin bad++; $display("FAIL add_opa_state got=%0d exp=1", state); end
        total++; if (operand_a !== 7'd42) begin bad++; $display("FAIL add_a got=%0d exp=42", operand_a); end
        total++; if (disp_val !== 14'd42) begin bad++; $display("FAIL add_disp_a got=%0d exp=42", disp_val); end
        drive(K_ADD, 0); dig(1); dig(7); idle();
        total++; if (state !== 2'b10) begin bad++; $display("FAIL add_opb_state got=%0d exp=2", state); end
        total++; if (operand_b !== 7'd17) begin bad++; $display("FAIL add_b got=%0d exp=17", operand_b); end
        total++; if (disp_val !== 14'd17) begin bad++; $display("FAIL add_disp_b got=%0d exp=17", disp_val); end
        drive(K_EQ, 0); idle();
        total++; if (result_mag !== 14'd59) begin bad++; $display("FAIL add_mag got=%0d exp=59", result_mag); end
        total++; if (result_neg !== 1'b0) begin bad++; $display("FAIL add_neg got=%0d exp=0", result_neg); end
        total++; if (state !== 2'b11) begin bad++; $display("FAIL add_res_state got=%0d exp=3", state); end
        total++; if (disp_val !== 14'd59) begin bad++; $display("FAIL add_disp_r got=%0d exp=59", disp_val); end
    endtask

    task automatic test_chain();
        drive(K_SUB, 0); idle();
        total++; if (state !== 2'b10) begin bad++; $display("FAIL chain_state got=%0d exp=2", state); end
        total++; if (operand_a !== 7'd59) begin bad++; $display("FAIL chain_a got=%0d exp=59", operand_a); end
        total++; if (op !== 2'b01) begin bad++; $display("FAIL chain_op got=%0d exp=1", op); end
        dig(9); drive(K_EQ, 0); idle();
        total++; if (result_mag !== 14'd50) begin bad++; $display("FAIL chain_mag got=%0d exp=50", result_mag); end
        total++; if (result_neg !== 1'b0) begin bad++; $display("FAIL chain_neg got=%0d exp=0", result_neg); end
    endtask

    task automatic test_sub_neg();
        drive(K_CLR, 0); dig(5); drive(K_SUB, 0); dig(1); dig(2);
        drive(K_EQ, 0); idle();
        total++; if (result_mag !== 14'd7) begin bad++; $display("FAIL subn_mag got=%0d exp=7", result_mag); end
        total++; if (result_neg !== 1'b1) begin bad++; $display("FAIL subn_neg got=%0d exp=1", result_neg); end
        total++; if (disp_val !== 14'd7) begin bad++; $display("FAIL subn_disp got=%0d exp=7", disp_val); end
    endtask

    task automatic test_digits();
        drive(K_CLR, 0); dig(4'd12); idle();
        total++; if (state !== 2'b00) begin bad++; $display("FAIL dig_gt9_state got=%0d exp=0", state); end
        dig(0); idle();
        total++; if (state !== 2'b01) begin bad++; $display("FAIL dig_zero_state got=%0d exp=1", state); end
        total++; if (operand_a !== 7'd0) begin bad++; $display("FAIL dig_zero_a got=%0d exp=0", operand_a); end
        dig(1); dig(2); dig(3); idle();
        total++; if (operand_a !== 7'd12) begin bad++; $display("FAIL dig_limit_a got=%0d exp=12", operand_a); end
        total++; if (disp_val !== 14'd12) begin bad++; $display("FAIL dig_limit_disp got=%0d exp=12", disp_val); end
    endtask

    task automatic test_mul();
        drive(K_CLR, 0); dig(9); dig(9); drive(K_MUL, 0); idle();
`ifdef CAL_MUL_EN
        total++; if (state !== 2'b10) begin bad++; $display("FAIL mul_state got=%0d exp=2", state); end
        total++; if (op !== 2'b10) begin bad++; $display("FAIL mul_op got=%0d exp=2", op); end
        dig(9); dig(9); drive(K_EQ, 0); idle();
        total++; if (result_mag !== 14'd9801) begin bad++; $display("FAIL mul_mag got=%0d exp=9801", result_mag); end
        total++; if (result_neg !== 1'b0) begin bad++; $display("FAIL mul_neg got=%0d exp=0", result_neg); end
`else
        total++; if (state !== 2'b01) begin bad++; $display("FAIL nomul_state got=%0d exp=1", state); end
        total++; if (op !== 2'b00) begin bad++; $display("FAIL nomul_op got=%0d exp=0", op); end
        total++; if (operand_a !== 7'd99) begin bad++; $display("FAIL nomul_a got=%0d exp=99", operand_a); end
`endif
    endtask

    task automatic test_chain_ignore();
        drive(K_CLR, 0); dig(9); dig(9); drive(K_ADD, 0); dig(2); dig(1);
        drive(K_EQ, 0); idle();
        total++; if (result_mag !== 14'd120) begin bad++; $display("FAIL big_mag got=%0d exp=120", result_mag); end
        drive(K_ADD, 0); idle();
        total++; if (state !== 2'b11) begin bad++; $display("FAIL big_state got=%0d exp=3", state); end
        total++; if (operand_a !== 7'd99) begin bad++; $display("FAIL big_a got=%0d exp=99", operand_a); end
        total++; if (disp_val !== 14'd120) begin bad++; $display("FAIL big_disp got=%0d exp=120", disp_val); end
    endtask

    task automatic test_op_replace();
        drive(K_CLR, 0); dig(3); drive(K_ADD, 0); drive(K_SUB, 0); idle();
        total++; if (op !== 2'b01) begin bad++; $display("FAIL repl_op got=%0d exp=1", op); end
        dig(4); drive(K_ADD, 0); idle();
        total++; if (op !== 2'b01) begin bad++; $display("FAIL repl_keep_op got=%0d exp=1", op); end
        total++; if (state !== 2'b10) begin bad++; $display("FAIL repl_state got=%0d exp=2", state); end
        drive(K_EQ, 0); idle();
        total++; if (result_mag !== 14'd1) begin bad++; $display("FAIL repl_mag got=%0d exp=1", result_mag); end
        total++; if (result_neg !== 1'b1) begin bad++; $display("FAIL repl_neg got=%0d exp=1", result_neg); end
    endtask

    task automatic test_priority();
        drive(K_CLR, 0); dig(5); drive(K_ADD | K_DIG, 8); idle();
        total++; if (state !== 2'b10) begin bad++; $display("FAIL prio_state got=%0d exp=2", state); end
        total++; if (operand_a !== 7'd5) begin bad++; $display("FAIL prio_a got=%0d exp=5", operand_a); end
        total++; if (operand_b !== 7'd0) begin bad++; $display("FAIL prio_b got=%0d exp=0", operand_b); end
        drive(K_SUB | K_MUL | K_DIG, 3); idle();
        total++; if (op !== 2'b01) begin bad++; $display("FAIL prio_op got=%0d exp=1", op); end
        total++; if (operand_b !== 7'd0) begin bad++; $display("FAIL prio_b2 got=%0d exp=0", operand_b); end
    endtask

    task automatic test_clr_eq();
        drive(K_CLR, 0); dig(8); drive(K_ADD, 0); dig(3); drive(K_EQ, 0);
        drive(K_ADD, 0); dig(3); idle();
        total++; if (operand_a !== 7'd11) begin bad++; $display("FAIL clreq_pre_a got=%0d exp=11", operand_a); end
        drive(K_CLR | K_EQ, 0); idle();
        total++; if (state !== 2'b00) begin bad++; $display("FAIL clreq_state got=%0d exp=0", state); end
        total++; if (op !== 2'b00) begin bad++; $display("FAIL clreq_op got=%0d exp=0", op); end
        total++; if (operand_a !== 7'd0) begin bad++; $display("FAIL clreq_a got=%0d exp=0", operand_a); end
        total++; if (operand_b !== 7'd0) begin bad++; $display("FAIL clreq_b got=%0d exp=0", operand_b); end
        total++; if (result_mag !== 14'd0) begin bad++; $display("FAIL clreq_mag got=%0d exp=0", result_mag); end
        total++; if (result_neg !== 1'b0) begin bad++; $display("FAIL clreq_neg got=%0d exp=0", result_neg); end
        total++; if (disp_val !== 14'd0) begin bad++; $display("FAIL clreq_disp got=%0d exp=0", disp_val); end
    endtask

    task automatic test_async_reset();
        drive(K_CLR, 0); dig(6); drive(K_SUB, 0); dig(5); idle();
        total++; if (operand_b !== 7'd5) begin bad++; $display("FAIL arst_pre_b got=%0d exp=5", operand_b); end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (state !== 2'b00) begin bad++; $display("FAIL arst_state got=%0d exp=0", state); end
        total++; if (op !== 2'b00) begin bad++; $display("FAIL arst_op got=%0d exp=0", op); end
        total++; if (operand_a !== 7'd0) begin bad++; $display("FAIL arst_a got=%0d exp=0", operand_a); end
        total++; if (operand_b !== 7'd0) begin bad++; $display("FAIL arst_b got=%0d exp=0", operand_b); end
        total++; if (disp_val !== 14'd0) begin bad++; $display("FAIL arst_disp got=%0d exp=0", disp_val); end
        #1;
        rst_n = 1'b1;
        idle();
        total++; if (state !== 2'b00) begin bad++; $display("FAIL arst_post_state got=%0d exp=0", state); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_chain();
        test_sub_neg();
        test_digits();
        test_mul();
        test_chain_ignore();
        test_op_replace();
        test_priority();
        test_clr_eq();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
